// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming CNN pipeline.
//  - state_t      : frame-control FSM states
//  - CFG_SEL_*    : cfg_sel encodings for the two weight banks
//  - sat_signed() : clamp a wide signed value to a w-bit signed range
//  - sat_relu()   : ReLU followed by a clamp to [0, 2^(w-1)-1]
// The helpers work on a fixed 64-bit container so that callers with any
// accumulator width can share them: sign-extend in, cast the result down.
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DISCARD,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam logic CFG_SEL_CONV = 1'b0;
    localparam logic CFG_SEL_FC   = 1'b1;

    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo = ~hi;   // -2^(w-1)
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        if (v[SAT_W-1]) begin
            return '0;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/cnn_conv1d_mac.sv
// 1-D convolution stage: keeps the last KERNEL_N-1 pixels of the frame,
// combines them with the incoming pixel, multiplies by the tap weights,
// sums in ACC_W bits, shifts, applies ReLU and saturates to DATA_W.
// The result is registered in the same cycle the pixel is accepted, so
// out_valid pulses one cycle after the in_valid that completed a window.
// Ports:
//  clk, rst   clock / asynchronous active-low reset
//  in_valid   pixel accepted this cycle
//  in_first   accepted pixel is the first of a new frame (restarts fill)
//  in_data    pixel (signed)
//  weights    KERNEL_N packed signed taps, tap k at [k*DATA_W +: DATA_W]
//  out_valid  one-cycle pulse with a new conv output
//  out_data   conv output after ReLU/saturation
// KERNEL_N must be at least 2.
module cnn_conv1d_mac
    import cnn_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int KERNEL_N   = 3,
    parameter int ACC_W      = 24,
    parameter int CONV_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_first,
    input  logic signed [DATA_W-1:0]     in_data,
    input  logic [KERNEL_N*DATA_W-1:0]   weights,
    output logic                         out_valid,
    output logic signed [DATA_W-1:0]     out_data
);

    localparam int FILL_W = $clog2(KERNEL_N);

    logic signed [DATA_W-1:0] hist_reg [KERNEL_N-1];
    logic signed [DATA_W-1:0] window   [KERNEL_N];
    logic signed [ACC_W-1:0]  prod     [KERNEL_N];
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_sh;
    logic [FILL_W-1:0]        fill_reg;
    logic [FILL_W-1:0]        fill_base;
    logic                     window_full;
    logic                     out_valid_reg;
    logic signed [DATA_W-1:0] out_data_reg;

    // Window seen by the MAC: stored history (oldest at index 0) plus the
    // pixel being accepted right now at the newest tap.
    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_N; gi++) begin : g_tap
            logic signed [DATA_W-1:0] w_val;
            logic signed [ACC_W-1:0]  w_ext;
            logic signed [ACC_W-1:0]  x_ext;
            if (gi < KERNEL_N - 1) begin : g_hist
                assign window[gi] = hist_reg[gi];
            end else begin : g_new
                assign window[gi] = in_data;
            end
            assign w_val    = weights[gi*DATA_W +: DATA_W];
            assign w_ext    = {{(ACC_W-DATA_W){w_val[DATA_W-1]}}, w_val};
            assign x_ext    = {{(ACC_W-DATA_W){window[gi][DATA_W-1]}}, window[gi]};
            assign prod[gi] = w_ext * x_ext;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < KERNEL_N; i++) begin
            sum = sum + prod[i];
        end
    end

    assign sum_sh = sum >>> CONV_SHIFT;

    // Fill count = pixels of this frame already held in history.
    assign fill_base   = in_first ? '0 : fill_reg;
    assign window_full = (fill_base == FILL_W'(KERNEL_N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KERNEL_N - 1; i++) begin
                hist_reg[i] <= '0;
            end
            fill_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= in_valid && window_full;
            if (in_valid) begin
                for (int i = 0; i < KERNEL_N - 1; i++) begin
                    hist_reg[i] <= window[i+1];
                end
                fill_reg     <= window_full ? fill_base : fill_base + FILL_W'(1);
                out_data_reg <= DATA_W'(sat_relu({{(SAT_W-ACC_W){sum_sh[ACC_W-1]}}, sum_sh}, DATA_W));
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: rtl/cnn_stream_pipe.sv
// Streaming CNN: 1-D conv -> ReLU -> max-pool -> FC dot product, one signed
// DATA_W result per frame of up to FRAME_LEN pixels.
// Ports:
//  clk, rst             clock / asynchronous active-low reset
//  s_valid/s_ready      pixel handshake; s_data pixel, s_last end of frame
//  cfg_we/sel/addr/data weight write (sel 0 = conv bank, 1 = FC bank),
//                       honoured only while idle, out-of-range addr dropped
//  m_valid/m_ready      result handshake; m_data saturated result,
//                       m_err frame-length mismatch (qualified by m_valid)
// Timing: pixel accepted at edge E0 -> conv result registered at E0 ->
// pool/FC accumulate at E1 -> m_data/m_valid registered at E2, so m_valid
// rises two cycles after the frame-end handshake (DRAIN lasts two cycles).
module cnn_stream_pipe
    import cnn_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int KERNEL_N   = 3,
    parameter int POOL_N     = 2,
    parameter int FRAME_LEN  = 16,
    parameter int ACC_W      = 24,
    parameter int CONV_SHIFT = 0,
    parameter int FC_SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [7:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_err
);

    localparam int CONV_N = FRAME_LEN - KERNEL_N + 1;
    localparam int FC_N   = CONV_N / POOL_N;
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int IDX_W  = $clog2(FC_N + 1);
    localparam int POOL_W = (POOL_N > 1) ? $clog2(POOL_N) : 1;

    state_t                   state_reg, state_next;
    logic                     s_ready_reg, s_ready_next;
    logic                     drain_reg;
    logic [CNT_W-1:0]         pix_cnt_reg, pix_cnt_inc;
    logic                     is_full;
    logic                     hs, accept, frame_end, hold_exit;
    logic                     err_reg;

    logic signed [DATA_W-1:0] conv_w_reg [KERNEL_N];
    logic [KERNEL_N*DATA_W-1:0] conv_w_flat;
    logic signed [DATA_W-1:0] fc_w_reg [FC_N];
    logic signed [DATA_W-1:0] fc_w_sel;
    logic                     cfg_conv_we, cfg_fc_we;

    logic                     conv_valid;
    logic signed [DATA_W-1:0] conv_data;

    logic [POOL_W-1:0]        pool_cnt_reg;
    logic signed [DATA_W-1:0] pool_max_reg, max_new;
    logic [IDX_W-1:0]         fc_idx_reg;
    logic signed [ACC_W-1:0]  fc_acc_reg, fc_prod, fc_sh;
    logic signed [ACC_W-1:0]  max_ext, fcw_ext;

    logic                     m_valid_reg, m_err_reg;
    logic signed [DATA_W-1:0] m_data_reg;

    // ---------------- handshake / frame tracking ----------------
    assign hs          = s_valid && s_ready_reg;
    assign accept      = hs && (state_reg == ST_IDLE || state_reg == ST_RUN);
    assign pix_cnt_inc = pix_cnt_reg + CNT_W'(1);
    assign is_full     = (pix_cnt_inc == CNT_W'(FRAME_LEN));
    assign frame_end   = accept && (s_last || is_full);
    assign hold_exit   = (state_reg == ST_HOLD) && m_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (hs) begin
                    if (s_last) begin
                        state_next = ST_DRAIN;
                    end else if (is_full) begin
                        state_next = ST_DISCARD;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_DISCARD: if (hs && s_last) state_next = ST_DRAIN;
            ST_DRAIN:   if (drain_reg)    state_next = ST_HOLD;
            ST_HOLD:    if (m_ready)      state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // s_ready is registered so it reads 0 while reset is asserted.
    assign s_ready_next = (state_next == ST_IDLE) || (state_next == ST_RUN) ||
                          (state_next == ST_DISCARD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            s_ready_reg <= 1'b0;
            drain_reg   <= 1'b0;
            pix_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            s_ready_reg <= s_ready_next;
            drain_reg   <= (state_reg == ST_DRAIN) ? ~drain_reg : 1'b0;
            if (hold_exit) begin
                pix_cnt_reg <= '0;
                err_reg     <= 1'b0;
            end else begin
                if (accept) pix_cnt_reg <= pix_cnt_inc;
                if (frame_end) err_reg <= (s_last != is_full);
            end
        end
    end

    // ---------------- weight banks ----------------
    assign cfg_conv_we = cfg_we && (state_reg == ST_IDLE) && (cfg_sel == CFG_SEL_CONV) &&
                         (cfg_addr < 8'(KERNEL_N));
    assign cfg_fc_we   = cfg_we && (state_reg == ST_IDLE) && (cfg_sel == CFG_SEL_FC) &&
                         (cfg_addr < 8'(FC_N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KERNEL_N; i++) conv_w_reg[i] <= '0;
            for (int i = 0; i < FC_N; i++)     fc_w_reg[i]   <= '0;
        end else begin
            for (int i = 0; i < KERNEL_N; i++) begin
                if (cfg_conv_we && cfg_addr == 8'(i)) conv_w_reg[i] <= cfg_data;
            end
            for (int i = 0; i < FC_N; i++) begin
                if (cfg_fc_we && cfg_addr == 8'(i)) fc_w_reg[i] <= cfg_data;
            end
        end
    end

    // The conv stage consumes a pixel in the same cycle as a concurrent
    // weight write, so the write is forwarded to keep "new weight wins".
    genvar gi;
    generate
        for (gi = 0; gi < KERNEL_N; gi++) begin : g_conv_w
            assign conv_w_flat[gi*DATA_W +: DATA_W] =
                (cfg_conv_we && cfg_addr == 8'(gi)) ? cfg_data : conv_w_reg[gi];
        end
    endgenerate

    cnn_conv1d_mac #(
        .DATA_W     (DATA_W),
        .KERNEL_N   (KERNEL_N),
        .ACC_W      (ACC_W),
        .CONV_SHIFT (CONV_SHIFT)
    ) u_conv (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_first  (state_reg == ST_IDLE),
        .in_data   (s_data),
        .weights   (conv_w_flat),
        .out_valid (conv_valid),
        .out_data  (conv_data)
    );

    // ---------------- max-pool + FC ----------------
    always_comb begin
        fc_w_sel = '0;
        for (int i = 0; i < FC_N; i++) begin
            if (fc_idx_reg == IDX_W'(i)) fc_w_sel = fc_w_reg[i];
        end
    end

    assign max_new = (pool_cnt_reg == '0 || conv_data > pool_max_reg) ? conv_data : pool_max_reg;
    assign max_ext = {{(ACC_W-DATA_W){max_new[DATA_W-1]}}, max_new};
    assign fcw_ext = {{(ACC_W-DATA_W){fc_w_sel[DATA_W-1]}}, fc_w_sel};
    assign fc_prod = max_ext * fcw_ext;
    assign fc_sh   = fc_acc_reg >>> FC_SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_cnt_reg <= '0;
            pool_max_reg <= '0;
            fc_idx_reg   <= '0;
            fc_acc_reg   <= '0;
        end else if (hold_exit) begin
            pool_cnt_reg <= '0;
            pool_max_reg <= '0;
            fc_idx_reg   <= '0;
            fc_acc_reg   <= '0;
        end else if (conv_valid) begin
            if (pool_cnt_reg == POOL_W'(POOL_N - 1)) begin
                // Window closed: fold into the dot product if an FC slot remains.
                pool_cnt_reg <= '0;
                if (fc_idx_reg < IDX_W'(FC_N)) begin
                    fc_acc_reg <= fc_acc_reg + fc_prod;
                    fc_idx_reg <= fc_idx_reg + IDX_W'(1);
                end
            end else begin
                pool_cnt_reg <= pool_cnt_reg + POOL_W'(1);
                pool_max_reg <= max_new;
            end
        end
    end

    // ---------------- result register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_err_reg   <= 1'b0;
        end else if (state_reg == ST_DRAIN && drain_reg) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= DATA_W'(sat_signed({{(SAT_W-ACC_W){fc_sh[ACC_W-1]}}, fc_sh}, DATA_W));
            m_err_reg   <= err_reg;
        end else if (hold_exit) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign s_ready = s_ready_reg;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_err   = m_err_reg;

endmodule

// File: tb/tb_cnn_stream_pipe.sv
module tb_cnn_stream_pipe;

    localparam int DATA_W    = 8;
    localparam int KERNEL_N  = 3;
    localparam int POOL_N    = 2;
    localparam int FRAME_LEN = 16;
    localparam int FC_N      = (FRAME_LEN - KERNEL_N + 1) / POOL_N;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     s_valid, s_ready, s_last;
    logic signed [DATA_W-1:0] s_data;
    logic                     cfg_we, cfg_sel;
    logic [7:0]               cfg_addr;
    logic signed [DATA_W-1:0] cfg_data;
    logic                     m_valid, m_ready, m_err;
    logic signed [DATA_W-1:0] m_data;

    typedef struct {
        int data;
        int err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   pix_q[$];
    int   cw_m[KERNEL_N];
    int   fw_m[FC_N];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;

    always #5 clk = ~clk;

    cnn_stream_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_err    (m_err)
    );

    task automatic check_val(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference: conv -> ReLU/sat -> pool -> FC -> sat over the first
    // FRAME_LEN pixels of the frame.
    function automatic int ref_result(input int pix[$]);
        int n;
        int conv[$];
        int acc;
        int s;
        int m;
        n   = (pix.size() > FRAME_LEN) ? FRAME_LEN : pix.size();
        acc = 0;
        for (int i = KERNEL_N - 1; i < n; i++) begin
            s = 0;
            for (int k = 0; k < KERNEL_N; k++) s += cw_m[k] * pix[i-KERNEL_N+1+k];
            if (s < 0) s = 0;
            if (s > 127) s = 127;
            conv.push_back(s);
        end
        for (int j = 0; j < conv.size() / POOL_N && j < FC_N; j++) begin
            m = conv[j*POOL_N];
            for (int p = 1; p < POOL_N; p++) if (conv[j*POOL_N+p] > m) m = conv[j*POOL_N+p];
            acc += m * fw_m[j];
        end
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return acc;
    endfunction

    // Result monitor: one line per output transaction.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            n_txn++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %0d: m_data=%0d m_err=%0d expected %0d/%0d",
                         n_txn, m_data, m_err, mon_e.data, mon_e.err);
                check_val("m_data", int'(m_data), mon_e.data);
                check_val("m_err", int'(m_err), mon_e.err);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(s_ready && !m_valid) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check_val("idle_timeout", 0, 1);
    endtask

    task automatic cfg_write(input bit sel, input int addr, input int val);
        wait_idle();
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 8'(addr); cfg_data = 8'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (sel == 1'b0 && addr < KERNEL_N) cw_m[addr] = val;
        if (sel == 1'b1 && addr < FC_N)     fw_m[addr] = val;
    endtask

    task automatic drive_pixel(input int val, input bit last);
        int n = 0;
        s_valid = 1'b1; s_data = 8'(val); s_last = last;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check_val("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Sends pix_q as one frame (s_last on the final pixel), pushes the
    // expected result, and checks the 2-cycle output latency.
    // first_cfg: write conv tap 0 = first_val together with pixel 1.
    // mid_cfg:   attempt a conv write during pixel 5 (must be dropped).
    task automatic send_frame(input bit first_cfg, input int first_val, input bit mid_cfg);
        exp_t e;
        int   n;
        wait_idle();
        if (first_cfg) cw_m[0] = first_val;
        e.data = ref_result(pix_q);
        e.err  = (pix_q.size() != FRAME_LEN) ? 1 : 0;
        sb_q.push_back(e);
        for (int i = 0; i < pix_q.size(); i++) begin
            cfg_we = 1'b0;
            if (first_cfg && i == 0) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd0; cfg_data = 8'(first_val);
            end
            if (mid_cfg && i == 4) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'd0; cfg_data = 8'sd50;
            end
            drive_pixel(pix_q[i], i == pix_q.size() - 1);
        end
        cfg_we = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_val("latency", n, 2);
    endtask

    task automatic fill_const(input int len, input int val);
        pix_q.delete();
        for (int i = 0; i < len; i++) pix_q.push_back(val);
    endtask

    task automatic load_defaults();
        for (int i = 0; i < KERNEL_N; i++) cfg_write(1'b0, i, 1);
        for (int i = 0; i < FC_N; i++)     cfg_write(1'b1, i, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_hold;
        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0; m_ready = 1'b1;
        for (int i = 0; i < KERNEL_N; i++) cw_m[i] = 0;
        for (int i = 0; i < FC_N; i++)     fw_m[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_s_ready", int'(s_ready), 0);
        check_val("rst_m_valid", int'(m_valid), 0);
        check_val("rst_m_data", int'(m_data), 0);
        check_val("rst_m_err", int'(m_err), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("idle_s_ready", int'(s_ready), 1);

        load_defaults();

        // 1: all ones -> 21
        fill_const(16, 1);   send_frame(1'b0, 0, 1'b0);
        // 2: conv saturation -> 127
        fill_const(16, 100); send_frame(1'b0, 0, 1'b0);
        // 3: ReLU kills negative conv; negative FC weights
        for (int i = 0; i < KERNEL_N; i++) cfg_write(1'b0, i, -1);
        fill_const(16, 5);   send_frame(1'b0, 0, 1'b0);
        for (int i = 0; i < KERNEL_N; i++) cfg_write(1'b0, i, 1);
        for (int i = 0; i < FC_N; i++)     cfg_write(1'b1, i, -1);
        fill_const(16, 1);   send_frame(1'b0, 0, 1'b0);
        for (int i = 0; i < FC_N; i++)     cfg_write(1'b1, i, 1);
        // 4: short and long frames
        fill_const(10, 1);   send_frame(1'b0, 0, 1'b0);
        fill_const(20, 1);   send_frame(1'b0, 0, 1'b0);

        // Random weights and pixels
        for (int i = 0; i < KERNEL_N; i++) cfg_write(1'b0, i, $urandom_range(8) - 4);
        for (int i = 0; i < FC_N; i++)     cfg_write(1'b1, i, $urandom_range(6) - 3);
        for (int r = 0; r < 3; r++) begin
            pix_q.delete();
            for (int i = 0; i < 16; i++) pix_q.push_back($urandom_range(255) - 128);
            send_frame(1'b0, 0, 1'b0);
        end
        load_defaults();

        // Out-of-range addresses are dropped
        cfg_write(1'b0, KERNEL_N, 99);
        cfg_write(1'b1, FC_N, 99);
        cfg_write(1'b1, 200, 99);
        fill_const(16, 1);   send_frame(1'b0, 0, 1'b0);

        // Weight write together with the first pixel takes effect
        fill_const(16, 1);   send_frame(1'b1, 2, 1'b0);
        cfg_write(1'b0, 0, 1);

        // 5: back-pressure in HOLD plus write attempt during RUN
        m_ready = 1'b0;
        fill_const(16, 2);
        exp_hold = ref_result(pix_q);
        send_frame(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_val("hold_m_data", int'(m_data), exp_hold);
            check_val("hold_m_valid", int'(m_valid), 1);
            check_val("hold_s_ready", int'(s_ready), 0);
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        fill_const(16, 1);   send_frame(1'b0, 0, 1'b0);

        // 6: reset mid-frame drops the frame and clears weights
        wait_idle();
        for (int i = 0; i < 7; i++) drive_pixel(1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check_val("midrst_m_valid", int'(m_valid), 0);
        check_val("midrst_m_data", int'(m_data), 0);
        check_val("midrst_m_err", int'(m_err), 0);
        check_val("midrst_s_ready", int'(s_ready), 0);
        for (int i = 0; i < KERNEL_N; i++) cw_m[i] = 0;
        for (int i = 0; i < FC_N; i++)     fw_m[i] = 0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        fill_const(16, 1);   send_frame(1'b0, 0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check_val("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
